// File: rtl/count_display_scan.sv
// Four-digit common-anode display for the 4-bit up counter: q in decimal on digits 1:0,
// BCD count of 15->0 wrap-arounds on digits 3:2, time-multiplexed by SCAN_DIV.
module count_display_scan #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [7:0] wrap_cnt
);

  localparam int unsigned       DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        BLANK    = 4'hF;

  logic [3:0]       r_q_d;
  logic [7:0]       r_wrap_cnt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;

  logic       w_wrap;
  logic       w_ge10;
  logic [3:0] w_d0, w_d1, w_d2, w_d3;
  logic [3:0] w_sel;
  logic [3:0] w_an;

  // Any digit value outside 0..9 (BLANK included) turns every segment off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  assign w_wrap = (r_q_d == 4'd15) && (q == 4'd0);

  always_comb begin
    w_ge10 = (q >= 4'd10);
    w_d0   = w_ge10 ? (q - 4'd10) : q;
    w_d1   = w_ge10 ? 4'd1 : BLANK;
    w_d2   = r_wrap_cnt[3:0];
    w_d3   = (r_wrap_cnt[7:4] == 4'd0) ? BLANK : r_wrap_cnt[7:4];
    case (r_idx)
      2'd0:    w_sel = w_d0;
      2'd1:    w_sel = w_d1;
      2'd2:    w_sel = w_d2;
      default: w_sel = w_d3;
    endcase
    w_an = ~(4'b0001 << r_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_d      <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_q_d <= q;
      if (w_wrap) begin
        if (r_wrap_cnt[3:0] == 4'd9) begin
          r_wrap_cnt[3:0] <= 4'd0;
          r_wrap_cnt[7:4] <= (r_wrap_cnt[7:4] == 4'd9) ? 4'd0 : r_wrap_cnt[7:4] + 4'd1;
        end else begin
          r_wrap_cnt[3:0] <= r_wrap_cnt[3:0] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= '1;
    end else begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_an  <= w_an;
      r_seg <= seg_code(w_sel);
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan with SCAN_DIV = 4: reset, scan order,
// free-running wrap counting, BCD rollover, non-wrap jumps and mid-run reset.
module tb_count_display_scan;

  localparam int unsigned SD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic [3:0] an;
  logic [7:0] seg;
  logic [7:0] wrap_cnt;

  int errors = 0;
  int checks = 0;

  count_display_scan #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .q        (q),
    .an       (an),
    .seg      (seg),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int n);
    bcd = {4'(n / 10), 4'(n % 10)};
  endfunction

  // Sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse between edges; the next posedge is edge 1 after release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic wrap_once();
    q = 4'd15; tick();
    q = 4'd0;  tick();
  endtask

  task automatic test_reset();
    q = 4'd7;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL reset_wrap got=%h exp=00", wrap_cnt); end
    #1;
    rst = 1'b0;
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_an got=%b exp=1110", an); end
    checks++; if (seg !== 8'hF8) begin errors++; $display("FAIL release_seg got=%h exp=f8", seg); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4];
    logic [7:0] exp_seg [4];
    int d;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{8'hB0, 8'hF9, 8'hC0, 8'hFF};
    q = 4'd13;
    do_reset();
    for (int e = 1; e <= 8 * SD; e++) begin
      tick();
      d = ((e - 1) / SD) % 4;
      checks++;
      if (an !== exp_an[d]) begin
        errors++; $display("FAIL scan_an edge=%0d got=%b exp=%b", e, an, exp_an[d]);
      end
      checks++;
      if (seg !== exp_seg[d]) begin
        errors++; $display("FAIL scan_seg edge=%0d got=%h exp=%h", e, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_free_run();
    int k = 0;
    q = 4'd0;
    do_reset();
    for (int e = 1; e <= 16 * 12 + 1; e++) begin
      q = 4'((e - 1) % 16);
      tick();
      if (q == 4'd0 && e > 1) k++;
      if (q == 4'd0 || q == 4'd15) begin
        checks++;
        if (wrap_cnt !== bcd(k)) begin
          errors++; $display("FAIL free_run edge=%0d got=%h exp=%h", e, wrap_cnt, bcd(k));
        end
      end
    end
    checks++;
    if (wrap_cnt !== 8'h12) begin errors++; $display("FAIL free_run_total got=%h exp=12", wrap_cnt); end
  endtask

  task automatic test_bcd_roll();
    int seen;
    q = 4'd0;
    do_reset();
    for (int i = 0; i < 9; i++) wrap_once();
    checks++; if (wrap_cnt !== 8'h09) begin errors++; $display("FAIL bcd_09 got=%h exp=09", wrap_cnt); end
    wrap_once();
    checks++; if (wrap_cnt !== 8'h10) begin errors++; $display("FAIL bcd_10 got=%h exp=10", wrap_cnt); end
    for (int i = 0; i < 89; i++) wrap_once();
    checks++; if (wrap_cnt !== 8'h99) begin errors++; $display("FAIL bcd_99 got=%h exp=99", wrap_cnt); end
    seen = 0;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      if (an == 4'b0111) begin
        seen++; checks++;
        if (seg !== 8'h90) begin errors++; $display("FAIL digit3_at_99 got=%h exp=90", seg); end
      end
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL digit3_seen_99 got=0 exp>0"); end
    wrap_once();
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL bcd_99_to_00 got=%h exp=00", wrap_cnt); end
    seen = 0;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      if (an == 4'b0111) begin
        seen++; checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL digit3_blank got=%h exp=ff", seg); end
      end
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL digit3_seen_00 got=0 exp>0"); end
  endtask

  task automatic test_nonwrap();
    q = 4'd0;
    do_reset();
    q = 4'd15; tick();
    q = 4'd3;  tick();
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL jump_15_3 got=%h exp=00", wrap_cnt); end
    q = 4'd14; tick();
    q = 4'd0;  tick();
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL jump_14_0 got=%h exp=00", wrap_cnt); end
    q = 4'd0;  tick();
    q = 4'd15; tick();
    q = 4'd0;  tick();
    checks++; if (wrap_cnt !== 8'h01) begin errors++; $display("FAIL jump_0_15_0 got=%h exp=01", wrap_cnt); end
  endtask

  task automatic test_reset_mid();
    q = 4'd0;
    do_reset();
    for (int i = 0; i < 47; i++) wrap_once();
    for (int i = 0; i < 12; i++) tick();
    // 106 edges since release: idx = 2 and an reflects idx 2.
    checks++; if (wrap_cnt !== 8'h47) begin errors++; $display("FAIL mid_pre_wrap got=%h exp=47", wrap_cnt); end
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got=%b exp=1011", an); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wrap_cnt !== 8'h00) begin errors++; $display("FAIL mid_rst_wrap got=%h exp=00", wrap_cnt); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_rst_an got=%b exp=1111", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL mid_rst_seg got=%h exp=ff", seg); end
    rst = 1'b0;
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_restart_an got=%b exp=1110", an); end
    checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL mid_restart_seg got=%h exp=c0", seg); end
  endtask

  initial begin
    rst = 1'b0;
    q   = 4'd0;
    test_reset();
    test_scan();
    test_free_run();
    test_bcd_roll();
    test_nonwrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_display_scan.md
# count_display_scan

Downstream consumer of the 4-bit up counter. It takes the counter value `q` (0–15) and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Digits 1:0 show `q` in decimal (00–15).
- Digits 3:2 show a two-digit BCD count of counter wrap-arounds (15→0 transitions), 00–99.

All state is clocked on the same `clk` and `rst` as the counter.

## Interface
- `SCAN_DIV`, default 16: clock cycles each digit stays enabled. Legal range is ≥2.
- `clk` input 1: system clock, shared with the counter.
- `rst` input 1: reset, asynchronous, active-high.
- `q` input 4: counter value, sampled on every `clk` rising edge.
- `an` output 4: digit enables, active-low. Bit i selects digit i; digit 0 is the rightmost.
- `seg` output 8: segment drive, active-low. `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `wrap_cnt` output 8: wrap count as BCD. `[7:4]` holds tens, `[3:0]` holds ones.

## Operation
- Input history: `q_d` is a register that holds the previous `q`. It updates every cycle.
- Wrap detect:
  - `wrap = (q_d == 4'd15) && (q == 4'd0)`.
  - Detection is value-based. Any 15→0 step counts, including one caused by external reset of the counter while this block is not in reset.
- Wrap counter:
  - On the edge where `wrap` = 1, increment the BCD ones digit.
  - Ones 9→0 carries into tens.
  - 99 wraps to 00; there is no saturation and no overflow flag.
- Digit data:
  - d0 = `q` mod 10.
  - d1 = 1 if `q` ≥ 10, else blank.
  - d2 = `wrap_cnt[3:0]`.
  - d3 = `wrap_cnt[7:4]`, blanked when it is 0.
- Decimal conversion is compare/subtract on 4 bits (`q` ≥ 10 → ones = `q` − 10). No divider is used.
- Scan logic:
  - `div` counts 0..`SCAN_DIV`−1.
  - When `div` = `SCAN_DIV`−1, `div` returns to 0 and `idx` (2 bits) advances 0→1→2→3→0.
- Output register: every cycle, `an` and `seg` load from the current `idx` and the current digit data.
  - `an` = one-hot-low of `idx`.
- Segment code (active-low, dp off, so `seg[7]` = 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF.
- Reset (async, immediate) clears:
  - `q_d` = 0, `wrap_cnt` = 8'h00, `div` = 0, `idx` = 0.
  - `an` = 4'b1111, `seg` = 8'hFF.
- Because `q_d` resets to 0, a shared reset of counter and display can never produce a false wrap.

## Timing
- `wrap_cnt` latency: it increments on the same edge at which `q` = 0 is first sampled after `q_d` = 15, i.e. one cycle after the counter produced 0.
- `an`/`seg` latency: they lag `idx` and digit data by exactly one cycle, registered.
  - A `q` change appears on `seg` at most one cycle later while its digit is selected.
- After `rst` deasserts:
  - First edge: `an` = 4'b1110, showing digit 0.
  - `idx` first advances on edge `SCAN_DIV`.
  - `an` changes to 4'b1101 on edge `SCAN_DIV`+1.
- Each digit is enabled for exactly `SCAN_DIV` consecutive cycles. A full frame is 4×`SCAN_DIV` cycles.
- `wrap` firing in the same cycle as a `div` rollover has no interaction: both updates occur.
- `rst` asserted mid-frame or mid-increment: all outputs take their reset values immediately, with no clock needed. A pending wrap is discarded.

## Test plan
- Reset: assert `rst` with `q` = 7 → `an` = 1111, `seg` = FF, `wrap_cnt` = 00 with no clock edge. Release → next edge gives `an` = 1110, `seg` = F8.
- Scan order, `SCAN_DIV` = 4, `q` = 13, `wrap_cnt` = 00: `an` sequence is 1110 (B0) ×4 cycles, 1101 (F9) ×4, 1011 (C0) ×4, 0111 (FF) ×4, then repeats.
- Free-running counter, 16 clocks per full count cycle: after 16 × 12 cycles, `wrap_cnt` = 8'h12. After each 15→0 step, `wrap_cnt` rises exactly one cycle later.
- BCD roll: `wrap_cnt` = 8'h09 + wrap → 8'h10. `wrap_cnt` = 8'h99 + wrap → 8'h00, and digit 3 becomes blank.
- Non-wrap jumps:
  - `q` 15→3 → no increment.
  - `q` 14→0 → no increment.
  - `q` 0→15→0 → exactly one increment.
- Reset mid-operation: with `wrap_cnt` = 8'h47 and `idx` = 2, pulse `rst` between edges → `wrap_cnt` = 00 and `an` = 1111 asynchronously. The scan restarts at digit 0.
